dffram_bist: RTL and testbench

DFFRAM_BIST -- requirements
Module: dffram_bist

---
 rtl/dffram_bist.sv | 160 ++++++++++++++++
 tb/tb_dffram_bist.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dffram_bist.sv
// March C- built-in self test for a single-port DFFRAM macro.
// Drives the RAM port directly and records the first failing address and element.
module dffram_bist #(
   parameter int                AW    = 9,
   parameter int                DW    = 32,
   parameter int                WSIZE = 4,
   parameter logic [DW-1:0]     BG    = 32'h5555_5555
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [AW-1:0]    fail_addr,
   output logic [2:0]       fail_elem,
   output logic             EN0,
   output logic [WSIZE-1:0] WE0,
   output logic [AW-1:0]    A0,
   output logic [DW-1:0]    Di0,
   input  logic [DW-1:0]    Do0
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [AW-1:0] ADDR_MAX = '1;
   localparam logic [AW-1:0] ADDR_ONE = AW'(1);
   localparam logic [2:0]    ELEM_LAST = 3'd5;

   state_t          state_q, state_d;
   logic [2:0]      elem_q, elem_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            wr_q, wr_d;           // current RUN cycle is a write
   logic [DW-1:0]   di_q, di_d;
   logic            cmp_q, cmp_d;         // Do0 carries read data this cycle
   logic [AW-1:0]   cmp_addr_q, cmp_addr_d;
   logic [2:0]      cmp_elem_q, cmp_elem_d;
   logic            fail_q, fail_d;
   logic [AW-1:0]   fail_addr_q, fail_addr_d;
   logic [2:0]      fail_elem_q, fail_elem_d;

   logic            mismatch;
   logic            single_op;
   logic            last_addr;
   logic [2:0]      elem_nxt;

   function automatic logic is_up(input logic [2:0] e);
      return (e == 3'd0) || (e == 3'd1) || (e == 3'd2) || (e == 3'd5);
   endfunction

   // M0/M2/M4 write "0" (BG); M1/M3 write "1".
   function automatic logic [DW-1:0] wpat(input logic [2:0] e);
      return e[0] ? ~BG : BG;
   endfunction

   // M2/M4 expect "1"; M1/M3/M5 expect "0".
   function automatic logic [DW-1:0] rpat(input logic [2:0] e);
      return ((e == 3'd2) || (e == 3'd4)) ? ~BG : BG;
   endfunction

   assign mismatch  = cmp_q && (Do0 != rpat(cmp_elem_q));
   assign single_op = (elem_q == 3'd0) || (elem_q == ELEM_LAST);
   assign last_addr = is_up(elem_q) ? (addr_q == ADDR_MAX) : (addr_q == '0);
   assign elem_nxt  = elem_q + 3'd1;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      addr_d      = addr_q;
      wr_d        = wr_q;
      cmp_d       = 1'b0;
      cmp_addr_d  = addr_q;
      cmp_elem_d  = elem_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;

      if (mismatch && !fail_q) begin
         fail_d      = 1'b1;
         fail_addr_d = cmp_addr_q;
         fail_elem_d = cmp_elem_q;
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = RUN;
               elem_d      = 3'd0;
               addr_d      = '0;
               wr_d        = 1'b1;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_elem_d = 3'd0;
            end
         end
         RUN: begin
            cmp_d = !wr_q;
            if (!single_op && !wr_q) begin
               wr_d = 1'b1;
            end else if (last_addr) begin
               if (elem_q == ELEM_LAST) begin
                  state_d = DRAIN;
               end else begin
                  elem_d = elem_nxt;
                  addr_d = is_up(elem_nxt) ? '0 : ADDR_MAX;
                  wr_d   = 1'b0;
               end
            end else begin
               addr_d = is_up(elem_q) ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
               wr_d   = (elem_q == 3'd0);
            end
         end
         DRAIN: state_d = DONE;
         default: state_d = IDLE;
      endcase

      di_d = (state_d == RUN) ? wpat(elem_d) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q     <= IDLE;
         elem_q      <= 3'd0;
         addr_q      <= '0;
         wr_q        <= 1'b0;
         di_q        <= '0;
         cmp_q       <= 1'b0;
         cmp_addr_q  <= '0;
         cmp_elem_q  <= 3'd0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         addr_q      <= addr_d;
         wr_q        <= wr_d;
         di_q        <= di_d;
         cmp_q       <= cmp_d;
         cmp_addr_q  <= cmp_addr_d;
         cmp_elem_q  <= cmp_elem_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
      end
   end

   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign done      = (state_q == DONE);
   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;
   assign fail_elem = fail_elem_q;
   assign EN0       = (state_q == RUN);
   assign WE0       = {WSIZE{(state_q == RUN) && wr_q}};
   assign A0        = addr_q;
   assign Di0       = di_q;

endmodule

// File: tb/tb_dffram_bist.sv
// Directed bench for dffram_bist: 512x32 RAM model with injectable stuck-at and decoder faults.
module tb_dffram_bist;

   logic        CLK;
   logic        RESETn;
   logic        start;
   logic        busy;
   logic        done;
   logic        fail;
   logic [8:0]  fail_addr;
   logic [2:0]  fail_elem;
   logic        EN0;
   logic [3:0]  WE0;
   logic [8:0]  A0;
   logic [31:0] Di0;
   logic [31:0] Do0;

   int n_checks = 0;
   int n_pass   = 0;

   // 0: fault-free, 1: stuck-at-1 bits at 0x1A5 (stuck_mask), 2: write to 0x100 also hits 0x000
   int          fault_mode = 0;
   logic [31:0] stuck_mask = 32'h0;
   logic [31:0] mem [512];

   // Per-run monitor captures, indexed by busy cycle number
   logic [8:0]  mon_a0_first;
   logic [31:0] mon_di_first;
   logic [3:0]  mon_we_first;
   logic [8:0]  mon_a0_m3_first;
   logic [8:0]  mon_a0_m3_last;
   logic [8:0]  mon_a0_m4_first;
   logic        mon_en_drain;
   int          mon_reads;
   int          mon_writes;

   dffram_bist #(.AW(9), .DW(32), .WSIZE(4), .BG(32'h5555_5555)) dut (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem),
      .EN0       (EN0),
      .WE0       (WE0),
      .A0        (A0),
      .Di0       (Di0),
      .Do0       (Do0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (EN0) begin
         if (WE0 != 4'h0) begin
            for (int b = 0; b < 4; b++) begin
               if (WE0[b]) begin
                  mem[A0][8*b +: 8] <= Di0[8*b +: 8];
                  if (fault_mode == 2 && A0 == 9'h100) mem[0][8*b +: 8] <= Di0[8*b +: 8];
               end
            end
         end else begin
            Do0 <= mem[A0] | ((fault_mode == 1 && A0 == 9'h1A5) ? stuck_mask : 32'h0);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      else n_pass++;
   endtask

   task automatic pulse_start();
      @(negedge CLK) start = 1'b1;
      @(negedge CLK) start = 1'b0;
   endtask

   // Called at the first busy negedge; returns busy cycle count, bounded.
   task automatic wait_done(output int n);
      n = 0;
      mon_reads  = 0;
      mon_writes = 0;
      while (!done && n < 6000) begin
         if (busy) begin
            if (n == 0) begin
               mon_a0_first = A0;
               mon_di_first = Di0;
               mon_we_first = WE0;
            end
            if (n == 2560) mon_a0_m3_first = A0;
            if (n == 3582) mon_a0_m3_last  = A0;
            if (n == 3584) mon_a0_m4_first = A0;
            if (n == 5120) mon_en_drain    = EN0;
            if (EN0 && WE0 == 4'h0) mon_reads++;
            if (EN0 && WE0 == 4'hF) mon_writes++;
            n++;
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      RESETn = 1'b0;
      start  = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fail", fail, 0);
      chk("rst_fail_addr", fail_addr, 0);
      chk("rst_fail_elem", fail_elem, 0);
      chk("rst_en0", EN0, 0);
      chk("rst_we0", WE0, 0);
      chk("rst_a0", A0, 0);
      chk("rst_di0", Di0, 0);
      repeat (2) @(negedge CLK);
      RESETn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("idle_no_access", {EN0, WE0}, 0);
      end
   endtask

   task automatic test_fault_free();
      int n;
      fault_mode = 0;
      pulse_start();
      wait_done(n);
      chk("ff_busy_cycles", n, 5121);
      chk("ff_done", done, 1);
      chk("ff_busy_low", busy, 0);
      chk("ff_fail", fail, 0);
      chk("ff_done_en0_we0", {EN0, WE0}, 0);
      chk("ff_first_a0", mon_a0_first, 9'h000);
      chk("ff_first_di0", mon_di_first, 32'h5555_5555);
      chk("ff_first_we0", mon_we_first, 4'hF);
      chk("ff_m3_first_a0", mon_a0_m3_first, 9'h1FF);
      chk("ff_m3_last_a0", mon_a0_m3_last, 9'h000);
      chk("ff_m4_first_a0", mon_a0_m4_first, 9'h1FF);
      chk("ff_drain_en0", mon_en_drain, 0);
      chk("ff_reads", mon_reads, 2560);
      chk("ff_writes", mon_writes, 2560);
      @(negedge CLK);
      chk("ff_done_sticky", done, 1);
   endtask

   // Bit 0 of BG is 1, so a stuck-at-1 there first shows on an M2 read of "1";
   // bit 1 of BG is 0, so stuck-at-1 there shows on the M1 read of "0".
   task automatic test_stuck(input logic [31:0] mask, input logic [2:0] exp_elem);
      int n;
      fault_mode = 1;
      stuck_mask = mask;
      pulse_start();
      wait_done(n);
      chk("sa_busy_cycles", n, 5121);
      chk("sa_fail", fail, 1);
      chk("sa_fail_addr", fail_addr, 9'h1A5);
      chk("sa_fail_elem", fail_elem, exp_elem);
      fault_mode = 0;
   endtask

   task automatic test_decoder();
      int n;
      fault_mode = 2;
      pulse_start();
      chk("dec_fail_cleared", fail, 0);
      chk("dec_done_cleared", done, 0);
      wait_done(n);
      chk("dec_busy_cycles", n, 5121);
      chk("dec_fail", fail, 1);
      chk("dec_fail_addr", fail_addr, 9'h000);
      chk("dec_fail_elem", fail_elem, 3);
      fault_mode = 0;
   endtask

   task automatic test_reset_mid();
      int n;
      pulse_start();
      repeat (1800) @(negedge CLK);
      chk("mid_in_run", {busy, EN0}, 2'b11);
      RESETn = 1'b0;
      #1;
      chk("mid_rst_en0", EN0, 0);
      chk("mid_rst_we0", WE0, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_a0", A0, 0);
      @(negedge CLK) RESETn = 1'b1;
      repeat (3) @(negedge CLK);
      chk("mid_idle_no_access", {busy, EN0, WE0}, 0);
      pulse_start();
      wait_done(n);
      chk("mid_busy_cycles", n, 5121);
      chk("mid_done", done, 1);
      chk("mid_fail", fail, 0);
   endtask

   task automatic test_start_held();
      int n;
      @(negedge CLK) start = 1'b1;
      @(negedge CLK);
      wait_done(n);
      chk("held_busy_cycles", n, 5121);
      chk("held_done", done, 1);
      @(negedge CLK);
      chk("held_restart_done", done, 0);
      chk("held_restart_busy", busy, 1);
      start = 1'b0;
      wait_done(n);
      chk("held_second_run", n, 5121);
      chk("held_second_fail", fail, 0);
   endtask

   initial begin
      test_reset();
      test_fault_free();
      test_stuck(32'h0000_0001, 3'd2);
      test_stuck(32'h0000_0002, 3'd1);
      test_decoder();
      test_reset_mid();
      test_start_held();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
